// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit scheduler:
// byte width, requester limit, FSM state type and the round-robin pick function.
package uart_pkg;

   localparam int BYTE_W  = 8;
   localparam int MAX_REQ = 8;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_DONE
   } txs_state_t;

   // Returns {valid, idx}: first set req[] at or after ptr+1, wrapping within n requesters.
   function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 n);
      logic [3:0] pick;
      int         idx;
      pick = '0;
      for (int k = 1; k <= MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % n;
         if ((k <= n) && !pick[3] && req[idx[2:0]]) begin
            pick = {1'b1, idx[2:0]};
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector; the pointer it searches from is owned
// by the scheduler FSM so that only actual grants move it.
module rr_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [2:0]         i_ptr,
   output logic               o_valid,
   output logic [2:0]         o_idx
);

   logic [3:0] w_pick;

   assign w_pick  = rr_pick(MAX_REQ'(i_req), i_ptr, NUM_REQ);
   assign o_valid = w_pick[3];
   assign o_idx   = w_pick[2:0];

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one uart_transmitter among NUM_REQ byte sources.
// Optional per-byte watchdog abort is compiled in with UART_TXS_TIMEOUT_EN.
module uart_tx_scheduler
   import uart_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int TIMEOUT_CYCLES = 1200000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [BYTE_W*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]        ack,
   output logic [NUM_REQ-1:0]        done,
   output logic                      tx_start,
   output logic [BYTE_W-1:0]         tx_data,
   input  logic                      tx_busy,
   input  logic                      tx_done,
   output logic [2:0]                grant_id,
   output logic                      sched_busy,
   output logic                      timeout_err
);

   txs_state_t          r_state, w_next;
   logic [2:0]          r_ptr, r_grant, w_pick_idx;
   logic                w_pick_vld, w_grant_now, w_waiting, w_frame_end, w_abort;
   logic [BYTE_W-1:0]   r_tx_data, w_pick_data;
   logic [NUM_REQ-1:0]  r_done;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .i_req   (req),
      .i_ptr   (r_ptr),
      .o_valid (w_pick_vld),
      .o_idx   (w_pick_idx)
   );

   always_comb begin
      w_pick_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_pick_idx == 3'(i)) w_pick_data = req_data[i*BYTE_W +: BYTE_W];
      end
   end

   // Never grant while the transmitter is still busy, including right after reset.
   assign w_grant_now = (r_state == IDLE) && w_pick_vld && !tx_busy;
   assign w_waiting   = (r_state == WAIT_BUSY) || (r_state == WAIT_DONE);
   assign w_frame_end = w_waiting && tx_done;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_grant_now) w_next = ISSUE;
         ISSUE:     w_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (tx_done || w_abort) w_next = IDLE;
            else if (tx_busy)       w_next = WAIT_DONE;
         end
         WAIT_DONE: if (tx_done || w_abort) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_ptr     <= 3'(NUM_REQ - 1);
         r_grant   <= '0;
         r_tx_data <= '0;
         r_done    <= '0;
      end else begin
         r_state <= w_next;
         r_done  <= w_frame_end ? (NUM_REQ'(1) << r_grant) : '0;
         if (w_grant_now) begin
            r_grant   <= w_pick_idx;
            r_ptr     <= w_pick_idx;
            r_tx_data <= w_pick_data;
         end
      end
   end

   assign tx_start   = (r_state == ISSUE);
   assign ack        = (r_state == ISSUE) ? (NUM_REQ'(1) << r_grant) : '0;
   assign done       = r_done;
   assign tx_data    = r_tx_data;
   assign grant_id   = r_grant;
   assign sched_busy = (r_state != IDLE);

`ifdef UART_TXS_TIMEOUT_EN
   localparam int              WD_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout;

   always_ff @(posedge clk) begin
      if (rst || (r_state == ISSUE)) r_wd_cnt <= '0;
      else if (w_waiting)            r_wd_cnt <= r_wd_cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) r_timeout <= 1'b0;
      else     r_timeout <= w_abort;
   end

   // Abort skips the done pulse; the pointer already moved at grant time.
   assign w_abort     = w_waiting && !tx_done && (r_wd_cnt == WD_LAST);
   assign timeout_err = r_timeout;
`else
   logic w_unused_cfg;
   assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
   assign w_abort      = 1'b0;
   assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler with a behavioural transmitter and round-robin scoreboard.
module tb_uart_tx_scheduler;

   localparam int NUM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  ack, done;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        tx_done = 1'b0;
   logic [2:0]  grant_id;
   logic        sched_busy, timeout_err;

   int n_checks = 0;
   int n_errs   = 0;

   always #5 clk = ~clk;

   uart_tx_scheduler #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(50)) dut (
      .clk         (clk),
      .rst         (rst),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .done        (done),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .grant_id    (grant_id),
      .sched_busy  (sched_busy),
      .timeout_err (timeout_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transmitter model: busy one cycle after start, done pulse 20 cycles later.
   bit m_busy = 0, m_active = 0, m_ext = 0, m_hang = 0, m_kill = 0;
   int m_cnt = 0;
   assign tx_busy = m_busy | m_ext;

   always @(posedge clk) begin
      tx_done <= 1'b0;
      if (m_kill) begin
         m_busy   <= 1'b0;
         m_active <= 1'b0;
      end else if (m_active) begin
         if (!m_hang && m_cnt == 19) begin
            tx_done  <= 1'b1;
            m_busy   <= 1'b0;
            m_active <= 1'b0;
         end
         m_cnt <= m_cnt + 1;
      end else if (tx_start) begin
         m_active <= 1'b1;
         m_busy   <= 1'b1;
         m_cnt    <= 0;
      end
   end

   function automatic int exp_pick(input logic [3:0] r, input int last);
      for (int k = 1; k <= NUM; k++) begin
         if (r[(last + k) % NUM]) return (last + k) % NUM;
      end
      return -1;
   endfunction

   // Scoreboard: request vector seen at each edge, expected winner, expected done.
   logic [3:0]  m_req_s = '0;
   logic [31:0] m_data_s = '0;
   always @(posedge clk) begin
      m_req_s  <= req;
      m_data_s <= req_data;
   end

   int m_last = NUM - 1, m_cur = 0, m_exp_idx = 0, m_e = 0;
   bit m_out = 0, m_exp_done = 0, m_prev_start = 0, m_to_seen = 0;
   int n_starts = 0, n_ack1 = 0;

   always @(negedge clk) begin
      if (m_exp_done) begin
         chk("sb_done", done, 32'(1 << m_exp_idx));
         m_exp_done = 0;
      end else if (done != 0) begin
         chk("sb_done_spurious", done, 0);
      end
      if (tx_start) begin
         n_starts++;
         if (ack[1]) n_ack1++;
         chk("sb_start_while_busy", tx_busy, 0);
         if (m_prev_start) chk("sb_issue_one_cycle", 1, 0);
         m_e = exp_pick(m_req_s, m_last);
         if (m_e < 0) begin
            chk("sb_start_without_req", 1, 0);
         end else begin
            chk("sb_grant", grant_id, m_e);
            chk("sb_ack", ack, 32'(1 << m_e));
            chk("sb_data", tx_data, m_data_s[m_e*8 +: 8]);
            m_last = m_e;
            m_cur  = m_e;
            m_out  = 1;
         end
      end else if (ack != 0) begin
         chk("sb_ack_without_start", ack, 0);
      end
      if (tx_done && m_out) begin
         m_exp_done = 1;
         m_exp_idx  = m_cur;
         m_out      = 0;
      end
`ifdef UART_TXS_TIMEOUT_EN
      if (timeout_err) begin
         m_to_seen = 1;
         m_out     = 0;
      end
`else
      if (timeout_err) chk("sb_timeout_tied_low", timeout_err, 0);
`endif
      m_prev_start = tx_start;
      if (rst) begin
         m_last     = NUM - 1;
         m_out      = 0;
         m_exp_done = 0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_start(input string name, input int bound);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (!tx_start && k < bound);
      if (!tx_start) chk({name, "_start_timeout"}, 0, 1);
   endtask

   task automatic wait_done(input string name, input logic [3:0] exp, input int bound);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (done == 0 && k < bound);
      chk({name, "_done"}, done, exp);
   endtask

   task automatic chk_idle(input string name);
      chk({name, "_ack"}, ack, 0);
      chk({name, "_done"}, done, 0);
      chk({name, "_tx_start"}, tx_start, 0);
      chk({name, "_tx_data"}, tx_data, 0);
      chk({name, "_grant_id"}, grant_id, 0);
      chk({name, "_sched_busy"}, sched_busy, 0);
      chk({name, "_timeout_err"}, timeout_err, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   typedef struct {
      logic [3:0] req;
      int         grant;
      logic [7:0] data;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int k, s0, a0;
      tbl[0] = '{4'b1111, 0, 8'h11};
      tbl[1] = '{4'b1111, 1, 8'h22};
      tbl[2] = '{4'b1111, 2, 8'h33};
      tbl[3] = '{4'b1111, 3, 8'h44};
      tbl[4] = '{4'b1111, 0, 8'h11};
      tbl[5] = '{4'b0100, 2, 8'h33};
      tbl[6] = '{4'b1010, 3, 8'h44};
      tbl[7] = '{4'b1010, 1, 8'h22};
      tbl[8] = '{4'b0001, 0, 8'h11};

      rst = 1'b1;
      step(); step(); step();
      chk_idle("reset");
      rst = 1'b0;

      // Single request after reset.
      req_data[7:0] = 8'hA5;
      req = 4'b0001;
      step();
      chk("t1_tx_start", tx_start, 1);
      chk("t1_ack", ack, 4'b0001);
      chk("t1_tx_data", tx_data, 8'hA5);
      chk("t1_grant", grant_id, 0);
      chk("t1_sched_busy", sched_busy, 1);
      req = '0;
      k = 0;
      do begin step(); k++; end while (!tx_done && k < 60);
      chk("t1_tx_done_seen", tx_done, 1);
      chk("t1_done_not_early", done, 0);
      step();
      chk("t1_done_next", done, 4'b0001);
      step();
      chk("t1_back_idle", sched_busy, 0);

      // Table-driven grant order; the next request pattern is applied right after each ack.
      do_reset();
      req_data = 32'h44332211;
      req = tbl[0].req;
      for (int i = 0; i < 9; i++) begin
         wait_start($sformatf("tbl%0d", i), 10);
         chk($sformatf("tbl%0d_grant", i), grant_id, tbl[i].grant);
         chk($sformatf("tbl%0d_data", i), tx_data, tbl[i].data);
         chk($sformatf("tbl%0d_ack", i), ack, 32'(1 << tbl[i].grant));
         req = (i < 8) ? tbl[i+1].req : 4'b0000;
         wait_done($sformatf("tbl%0d", i), 4'(1 << tbl[i].grant), 60);
      end
      step();

      // Transmitter busy with a foreign frame blocks the grant.
      m_ext = 1;
      step();
      req = 4'b0100;
      k = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tx_start) k++;
      end
      chk("t3_no_start_while_busy", k, 0);
      m_ext = 0;
      step();
      chk("t3_start_after_idle", tx_start, 1);
      chk("t3_grant", grant_id, 2);
      chk("t3_data", tx_data, 8'h33);
      req = '0;
      wait_done("t3", 4'b0100, 60);
      step();

      // Short req[1] pulse while another byte is in flight is never acked.
      req = 4'b0001;
      wait_start("t6", 10);
      req = '0;
      step(); step(); step(); step(); step();
      s0 = n_starts;
      a0 = n_ack1;
      req = 4'b0010;
      step();
      req = '0;
      wait_done("t6", 4'b0001, 60);
      for (int i = 0; i < 10; i++) step();
      chk("t6_start_count", n_starts, s0);
      chk("t6_ack1_count", n_ack1, a0);

      // Reset while waiting for the frame: outputs clear, no done, next grant is clean.
      req = 4'b0001;
      wait_start("t4a", 10);
      req = '0;
      step(); step(); step(); step(); step();
      chk("t4_in_wait_done", tx_busy, 1);
      rst = 1'b1;
      step();
      chk_idle("t4_reset");
      rst = 1'b0;
      req_data[31:24] = 8'h3C;
      req = 4'b1000;
      wait_start("t4b", 40);
      chk("t4_grant", grant_id, 3);
      chk("t4_data", tx_data, 8'h3C);
      chk("t4_ack", ack, 4'b1000);
      req = '0;
      wait_done("t4b", 4'b1000, 60);
      step();

`ifdef UART_TXS_TIMEOUT_EN
      // Hung transmitter: watchdog aborts and the other pending requester follows.
      m_hang = 1;
      req = 4'b0011;
      wait_start("t5a", 10);
      chk("t5_first_grant", grant_id, 0);
      req = 4'b0010;
      k = 0;
      do begin step(); k++; end while (!timeout_err && k < 100);
      chk("t5_timeout_seen", timeout_err, 1);
      chk("t5_timeout_window", (k >= 49 && k <= 52), 1);
      chk("t5_no_done", done, 0);
      m_kill = 1;
      m_hang = 0;
      step();
      m_kill = 0;
      wait_start("t5b", 10);
      chk("t5_next_grant", grant_id, 1);
      chk("t5_next_data", tx_data, 8'h22);
      req = '0;
      wait_done("t5b", 4'b0010, 60);
      step();
`endif

      // Random requesters: hold until ack, then drop or occasionally keep requesting.
      s0 = n_starts;
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int i = 0; i < NUM; i++) begin
            if (req[i] && ack[i]) begin
               if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 7) == 0) begin
               req_data[i*8 +: 8] = 8'($urandom);
               req[i] = 1'b1;
            end
         end
      end
      req = '0;
      k = 0;
      do begin step(); k++; end while ((sched_busy || tx_busy) && k < 200);
      chk("rand_drain_idle", sched_busy, 0);
      chk("rand_progress", (n_starts - s0) > 20, 1);
`ifdef UART_TXS_TIMEOUT_EN
      chk("t5_timeout_flag", m_to_seen, 1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errs);
      $fatal(1);
   end

endmodule
